// File: rtl/aurora_pkg.sv
`default_nettype none
// ============================================================================
// Module : aurora_pkg
// Brief  : Shared constants and symbol encoding for the multilane idle generator.
// Rev    : 1.0  initial release
// ============================================================================
package aurora_pkg;

   localparam int           c_lfsr_w            = 8;
   // x^8+x^6+x^5+x^4+1 as a shift-left Fibonacci tap mask (bits 7,5,4,3)
   localparam logic [7:0]   c_lfsr_taps         = 8'hB8;
   localparam logic [4:0]   c_a_base            = 5'd16;
   localparam int           c_cc_period_default = 5000;
   localparam int           c_cc_len_default    = 6;

   typedef enum logic [2:0] {
      SYM_NONE,
      SYM_K,
      SYM_A,
      SYM_R,
      SYM_CC
   } idle_sym_t;

endpackage
`default_nettype wire

// File: rtl/aurora_lfsr.sv
`default_nettype none
// ============================================================================
// Module : aurora_lfsr
// Brief  : Free-running Fibonacci LFSR with seed load on reset and step enable.
// Rev    : 1.0  initial release
// ============================================================================
module aurora_lfsr
   import aurora_pkg::*;
#(
   parameter int               WIDTH = c_lfsr_w,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hA5),
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(c_lfsr_taps)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] state
);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SEED;
      end else if (en) begin
         state <= {state[WIDTH-2:0], ^(state & TAPS)};
      end
   end

endmodule
`default_nettype wire

// File: rtl/multilane_idle_generator.sv
`default_nettype none
// ============================================================================
// Module : multilane_idle_generator
// Brief  : Per-lane /K/ /A/ /R/ idle symbol requests with periodic CC bursts.
// Rev    : 1.0  initial release
// ============================================================================
module multilane_idle_generator
   import aurora_pkg::*;
#(
   parameter int         LANES     = 2,
   parameter logic [7:0] LFSR_SEED = 8'hA5,
   parameter int         CC_PERIOD = c_cc_period_default,
   parameter int         CC_LEN    = c_cc_len_default
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             send_idle,
   output logic [LANES-1:0] send_K,
   output logic [LANES-1:0] send_A,
   output logic [LANES-1:0] send_R,
   output logic [LANES-1:0] send_CC,
   output logic             cc_active
);

   localparam int             c_pw          = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
   localparam logic [c_pw-1:0] c_period_last = c_pw'(CC_PERIOD - 1);

   typedef enum logic [0:0] {
      ST_RUN,
      ST_CC
   } state_t;

   state_t          r_state;
   logic [3:0]      r_cc_left;
   logic [c_pw-1:0] r_period;
   logic [4:0]      r_a_cnt;
   logic [7:0]      w_lfsr;
   logic            w_lfsr_unused;
   logic            w_cc_start;
   logic            w_cc_busy;
   logic            w_idle_ok;
   logic            w_emit_a;
   idle_sym_t       w_sym [LANES];

   aurora_lfsr #(
      .WIDTH (c_lfsr_w),
      .SEED  (LFSR_SEED),
      .TAPS  (c_lfsr_taps)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (1'b1),
      .state (w_lfsr)
   );

   assign w_lfsr_unused = ^w_lfsr;

   // w_cc_busy is the burst state the outputs will show after this edge
   assign w_cc_start = (r_period == c_period_last);
   assign w_cc_busy  = w_cc_start || ((r_state == ST_CC) && (r_cc_left != 4'd0));
   assign w_idle_ok  = send_idle && !w_cc_busy;
   assign w_emit_a   = w_idle_ok && (r_a_cnt == 5'd0);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int c_bit = i % c_lfsr_w;
      assign w_sym[i] = w_cc_busy      ? SYM_CC   :
                        !send_idle     ? SYM_NONE :
                        w_emit_a       ? SYM_A    :
                        w_lfsr[c_bit]  ? SYM_K    : SYM_R;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_RUN;
         r_cc_left <= 4'd0;
         r_period  <= '0;
         r_a_cnt   <= 5'd0;
         cc_active <= 1'b0;
      end else begin
         r_period  <= (r_period == c_period_last) ? '0 : r_period + 1'b1;
         cc_active <= w_cc_busy;
         case (r_state)
            ST_RUN: begin
               if (w_cc_start) begin
                  r_state   <= ST_CC;
                  r_cc_left <= 4'(CC_LEN - 1);
               end
            end
            ST_CC: begin
               if (r_cc_left == 4'd0) begin
                  r_state <= ST_RUN;
               end else begin
                  r_cc_left <= r_cc_left - 4'd1;
               end
            end
            default: r_state <= ST_RUN;
         endcase
         // The A spacing only counts idle cycles that actually emit a symbol
         if (w_idle_ok) begin
            r_a_cnt <= w_emit_a ? (c_a_base + {1'b0, w_lfsr[3:0]}) : (r_a_cnt - 5'd1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         send_K  <= '0;
         send_A  <= '0;
         send_R  <= '0;
         send_CC <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            send_K[i]  <= (w_sym[i] == SYM_K);
            send_A[i]  <= (w_sym[i] == SYM_A);
            send_R[i]  <= (w_sym[i] == SYM_R);
            send_CC[i] <= (w_sym[i] == SYM_CC);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multilane_idle_generator.sv
`default_nettype none
// ============================================================================
// Module : tb_multilane_idle_generator
// Brief  : Directed self-checking bench for 1-, 2- and 8-lane idle generators.
// Rev    : 1.0  initial release
// ============================================================================
module tb_multilane_idle_generator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       send_idle;
   logic [1:0] k2, a2, r2, cc2;
   logic       act2;
   logic [0:0] k1, a1, r1, cc1;
   logic       act1;
   logic [7:0] k8, a8, r8, cc8;
   logic       act8;

   multilane_idle_generator #(.LANES(2), .LFSR_SEED(8'hA5), .CC_PERIOD(40), .CC_LEN(6)) dut (
      .clk(clk), .rst(rst), .send_idle(send_idle),
      .send_K(k2), .send_A(a2), .send_R(r2), .send_CC(cc2), .cc_active(act2));

   multilane_idle_generator #(.LANES(1), .LFSR_SEED(8'hA5), .CC_PERIOD(40), .CC_LEN(6)) dut1 (
      .clk(clk), .rst(rst), .send_idle(send_idle),
      .send_K(k1), .send_A(a1), .send_R(r1), .send_CC(cc1), .cc_active(act1));

   multilane_idle_generator #(.LANES(8), .LFSR_SEED(8'hA5), .CC_PERIOD(40), .CC_LEN(6)) dut8 (
      .clk(clk), .rst(rst), .send_idle(send_idle),
      .send_K(k8), .send_A(a8), .send_R(r8), .send_CC(cc8), .cc_active(act8));

   int         checks = 0;
   int         errors = 0;
   int         cyc;
   int         exp_gap;
   int         kr_cnt;
   logic [7:0] m_lfsr;
   logic [7:0] used;
   logic       s_rst;
   logic       s_idle;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Captures what the DUT sampled, then steps past the edge
   task automatic tick();
      s_rst  = rst;
      s_idle = send_idle;
      used   = m_lfsr;
      @(posedge clk);
      #1;
      if (s_rst) begin
         m_lfsr = 8'hA5;
         cyc    = 0;
      end else begin
         m_lfsr = lfsr_next(m_lfsr);
         cyc++;
      end
   endtask

   task automatic check_cycle();
      logic in_cc;
      logic exp_a;
      in_cc = !s_rst && (cyc >= 40) && ((cyc % 40) < 6);
      if (s_rst || (!in_cc && !s_idle)) begin
         if (s_rst) begin
            exp_gap = -1;
            kr_cnt  = 0;
         end
         chk("quiet2", {k2, a2, r2, cc2}, 8'h00);
         chk("quiet2_act", {7'b0, act2}, 8'h00);
         chk("quiet8", k8 | a8 | r8 | cc8, 8'h00);
         chk("quiet1", {3'b0, act1, k1, a1, r1, cc1}, 8'h00);
      end else if (in_cc) begin
         chk("cc_send", {6'b0, cc2}, 8'h03);
         chk("cc_act", {7'b0, act2}, 8'h01);
         chk("cc_kar", {2'b0, k2, a2, r2}, 8'h00);
         chk("cc8_send", cc8, 8'hFF);
         chk("cc8_kar", k8 | a8 | r8, 8'h00);
         chk("cc1", {4'b0, act1, cc1, k1 | a1 | r1, 1'b0}, 8'h0C);
      end else begin
         exp_a = (exp_gap < 0) || (kr_cnt == exp_gap);
         chk("idle_A", {6'b0, a2}, exp_a ? 8'h03 : 8'h00);
         chk("idle_K", {6'b0, k2}, exp_a ? 8'h00 : {6'b0, used[1:0]});
         chk("idle_R", {6'b0, r2}, exp_a ? 8'h00 : {6'b0, ~used[1:0]});
         chk("idle_cc", {5'b0, act2, cc2}, 8'h00);
         chk("idle8_A", a8, exp_a ? 8'hFF : 8'h00);
         chk("idle8_K", k8, exp_a ? 8'h00 : used);
         chk("idle8_R", r8, exp_a ? 8'h00 : ~used);
         chk("idle8_cc", {7'b0, act8} | cc8, 8'h00);
         chk("idle1", {4'b0, act1, a1, k1, r1}, exp_a ? 8'h04 : {6'b0, used[0], ~used[0]});
         if (exp_a) begin
            exp_gap = 16 + int'(used[3:0]);
            kr_cnt  = 0;
         end else begin
            kr_cnt++;
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      send_idle = 1'b0;
      cyc       = 0;
      exp_gap   = -1;
      kr_cnt    = 0;
      m_lfsr    = 8'hA5;
      tick();
      tick();
      check_cycle();

      // Idle held, with send_idle wiggled inside each CC burst
      rst = 1'b0;
      for (int n = 0; n < 120; n++) begin
         if ((cyc + 1) >= 40 && ((cyc + 1) % 40) < 6) send_idle = cyc[0];
         else                                         send_idle = 1'b1;
         tick();
         check_cycle();
         if (cyc == 1)  chk("first_A", {6'b0, a2}, 8'h03);
         if (cyc == 2)  chk("c2_KR", {4'b0, k2, r2}, 8'h09);
         if (cyc == 3)  chk("c3_KR", {4'b0, k2, r2}, 8'h06);
         if (cyc == 5)  chk("c5_KR", {4'b0, k2, r2}, 8'h03);
         if (cyc == 22) chk("c22_noA", {6'b0, a2}, 8'h00);
         if (cyc == 23) chk("c23_A", {6'b0, a2}, 8'h03);
         if (cyc == 39) chk("c39_act", {7'b0, act2}, 8'h00);
         if (cyc == 40) chk("c40_act", {7'b0, act2}, 8'h01);
         if (cyc == 45) chk("c45_act", {7'b0, act2}, 8'h01);
         if (cyc == 46) chk("c46_act", {7'b0, act2}, 8'h00);
         if (cyc == 80) chk("c80_cc", {6'b0, cc2}, 8'h03);
         if (cyc == 86) chk("c86_act", {7'b0, act2}, 8'h00);
      end

      // send_idle toggling 1/0 every three cycles, crossing a burst
      for (int n = 0; n < 60; n++) begin
         send_idle = ((n / 3) % 2) == 0;
         tick();
         check_cycle();
      end

      // Reset asserted on the third cycle of a burst
      send_idle = 1'b1;
      for (int n = 0; n < 100 && cyc != 202; n++) begin
         tick();
         check_cycle();
      end
      chk("pre_rst_act", {7'b0, act2}, 8'h01);
      rst = 1'b1;
      tick();
      check_cycle();
      chk("rst_mid_act", {7'b0, act2}, 8'h00);
      rst = 1'b0;
      tick();
      check_cycle();
      chk("post_rst_A", {6'b0, a2}, 8'h03);
      chk("post_rst_A8", a8, 8'hFF);
      for (int n = 0; n < 50; n++) begin
         tick();
         check_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multilane_idle_generator.md
MULTILANE_IDLE_GENERATOR -- requirements
Module: multilane_idle_generator

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning number of lanes driven (legal range 1..8).
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5, meaning the non-zero 8-bit LFSR reset value.
REQ-003 SHALL have parameter CC_PERIOD, default 5000, meaning the number of cycles from one CC burst start to the next (legal: > CC_LEN+1).
REQ-004 SHALL have parameter CC_LEN, default 6, meaning the CC burst length in cycles (legal range 1..15).
REQ-005 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port send_idle  input  1  upstream has no data and requests idle symbols.
REQ-008 SHALL have port send_K  output  LANES  per-lane /K/ comma request.
REQ-009 SHALL have port send_A  output  LANES  per-lane /A/ alignment request.
REQ-010 SHALL have port send_R  output  LANES  per-lane /R/ request.
REQ-011 SHALL have port send_CC  output  LANES  per-lane clock-compensation request.
REQ-012 SHALL have port cc_active  output  1  CC burst in progress; upstream must stall data.

Function
REQ-013 All outputs SHALL be registered; send_idle sampled at cycle n affects outputs at n+1.
REQ-014 The 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every non-reset cycle, regardless of send_idle.
REQ-015 The A-spacing counter (5 bit) SHALL decrement only on cycles with send_idle=1 and no CC burst in progress.
REQ-016 The A-spacing counter SHALL be frozen at its current value otherwise.
REQ-017 When send_idle=1, no CC burst is in progress and the A counter is 0, all lanes SHALL assert send_A.
REQ-018 In the cycle that emits /A/, the A counter SHALL reload with 16 + lfsr[3:0], giving a spacing of 16..31 idle cycles.
REQ-019 On any other idle cycle, lane i SHALL assert send_K if lfsr[i mod 8]=1, else send_R.
REQ-020 Per lane, at most one of send_K/send_A/send_R/send_CC SHALL be high in any cycle.
REQ-021 With send_idle=0 and no CC burst in progress, send_K, send_A and send_R SHALL all be 0.
REQ-022 The period counter SHALL count 0..CC_PERIOD-1 every cycle and wrap to 0.
REQ-023 The cycle after the period counter equals CC_PERIOD-1, a CC burst SHALL start.
REQ-024 During a CC burst, cc_active and all send_CC bits SHALL be 1 for exactly CC_LEN cycles.
REQ-025 A CC burst SHALL preempt idle symbols; send_idle is ignored for the whole burst.
REQ-026 A CC burst SHALL NOT be truncated or extended by send_idle.
REQ-027 The period counter SHALL keep running during a CC burst (period measured start-to-start).
REQ-028 If send_idle=1 in the first cycle after a burst ends, the next idle cycle SHALL resume with the frozen A counter value.

Reset
REQ-029 On rst=1 at a clock edge, all outputs SHALL be 0 at the next cycle.
REQ-030 On rst=1 at a clock edge, the LFSR SHALL load LFSR_SEED, the A counter 0 and the period counter 0.
REQ-031 Reset mid-burst SHALL abort the burst immediately (cc_active=0 next cycle).
REQ-032 After reset release, the first idle cycle SHALL emit /A/ on all lanes.

Structure
REQ-033 aurora_pkg SHALL hold the LFSR polynomial tap constant, the A base spacing (16), the CC_PERIOD/CC_LEN defaults and an idle_sym_t enum {SYM_NONE, SYM_K, SYM_A, SYM_R, SYM_CC}.
REQ-034 A single sub-module aurora_lfsr SHALL be instantiated, parameterised by width and seed, with enable and state output.

Verification
REQ-035 Reset, then send_idle=1 held -> first output cycle has send_A=all ones; every subsequent /A/ gap is 16..31 cycles.
REQ-036 send_idle=1 held for 2000 cycles, LANES=2 -> each cycle exactly one-hot per lane; K and R both present on each lane.
REQ-037 CC_PERIOD=40, CC_LEN=6 -> cc_active high at cycles 40..45, 80..85 after reset release; send_CC=2'b11 there; K/A/R=0.
REQ-038 send_idle toggling 1/0 every 3 cycles -> outputs 0 exactly one cycle after each send_idle=0 sample; A-counter gaps counted in idle cycles only.
REQ-039 rst pulsed at the 3rd cycle of a CC burst -> cc_active=0 next cycle; first /A/ again on the first idle cycle after release.
REQ-040 LANES=1 and LANES=8 elaborations -> same A timing as LANES=2 from the same seed; lane i K/R choice matches lfsr[i].
